// File: rtl/execute_stage_md_if.sv
// Execute-stage bundle: decoded controls and operands from ID/EX, plus results towards EX/MEM and the hazard unit.
interface execute_stage_md_if #(
    parameter int XLEN = 32
);
    logic            ValidE;
    logic            FlushE;
    logic            JumpE;
    logic            JalrE;
    logic            BranchE;
    logic            ALUSrcE;
    logic            MulDivE;
    logic [2:0]      BranchCondE;
    logic [2:0]      MDOpE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ExtImmE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] ResultW;
    logic [XLEN-1:0] ResultE;
    logic [XLEN-1:0] WriteDataE;
    logic [XLEN-1:0] PCTargetE;
    logic            PCSrcE;
    logic            StallMDE;
    logic            MDDoneE;

    modport master (
        output ValidE, FlushE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE,
               BranchCondE, MDOpE, ForwardAE, ForwardBE, ALUControlE,
               PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW,
        input  ResultE, WriteDataE, PCTargetE, PCSrcE, StallMDE, MDDoneE
    );

    modport slave (
        input  ValidE, FlushE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE,
               BranchCondE, MDOpE, ForwardAE, ForwardBE, ALUControlE,
               PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW,
        output ResultE, WriteDataE, PCTargetE, PCSrcE, StallMDE, MDDoneE
    );
endinterface

// File: rtl/execute_stage_md.sv
// RV32I execute stage with branch/JALR resolution and an iterative RV32M unit.
// The multiply/divide unit is built only when EXEC_MULDIV_EN is defined.
module execute_stage_md #(
    parameter int XLEN          = 32,
    parameter int MD_RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    execute_stage_md_if.slave ex_if
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] as;
        logic signed [XLEN-1:0] bs;
        logic [SHW-1:0]         sh;
        as = a;
        bs = b;
        sh = b[SHW-1:0];
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLT:   return {{(XLEN-1){1'b0}}, (as < bs)};
            ALU_SLTU:  return {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:   return a << sh;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return $unsigned(as >>> sh);
            ALU_PASSB: return b;
            default:   return '0;
        endcase
    endfunction

    logic [XLEN-1:0]        src_a;
    logic [XLEN-1:0]        fwd_b;
    logic [XLEN-1:0]        src_b;
    logic [XLEN-1:0]        alu_y;
    logic [XLEN-1:0]        jalr_sum;
    logic signed [XLEN-1:0] src_a_s;
    logic signed [XLEN-1:0] src_b_s;
    logic                   taken;

    always_comb begin
        case (ex_if.ForwardAE)
            2'b00:   src_a = ex_if.RD1E;
            2'b01:   src_a = ex_if.ResultW;
            2'b10:   src_a = ex_if.ALUResultM;
            default: src_a = '0;
        endcase
        case (ex_if.ForwardBE)
            2'b00:   fwd_b = ex_if.RD2E;
            2'b01:   fwd_b = ex_if.ResultW;
            2'b10:   fwd_b = ex_if.ALUResultM;
            default: fwd_b = '0;
        endcase
    end

    assign src_b   = ex_if.ALUSrcE ? ex_if.ExtImmE : fwd_b;
    assign src_a_s = src_a;
    assign src_b_s = src_b;
    assign alu_y   = alu_f(ex_if.ALUControlE, src_a, src_b);

    always_comb begin
        case (ex_if.BranchCondE)
            3'b000:  taken = (src_a == src_b);
            3'b001:  taken = (src_a != src_b);
            3'b100:  taken = (src_a_s < src_b_s);
            3'b101:  taken = (src_a_s >= src_b_s);
            3'b110:  taken = (src_a < src_b);
            3'b111:  taken = (src_a >= src_b);
            default: taken = 1'b0;
        endcase
    end

    // JALR targets must be halfword-aligned, so bit 0 of the sum is dropped.
    assign jalr_sum         = src_a + ex_if.ExtImmE;
    assign ex_if.PCTargetE  = ex_if.JalrE ? {jalr_sum[XLEN-1:1], 1'b0}
                                          : ex_if.PCE + ex_if.ExtImmE;
    assign ex_if.PCSrcE     = ex_if.ValidE & ~ex_if.FlushE &
                              (ex_if.JumpE | (ex_if.BranchE & taken));
    assign ex_if.WriteDataE = fwd_b;

`ifdef EXEC_MULDIV_EN
    localparam int ITERS = XLEN / MD_RADIX_BITS;
    localparam int CNTW  = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(ITERS - 1);

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

    md_state_e       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            start;
    logic            done;
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] it_hi, it_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fin;

    assign a_sgn = (ex_if.MDOpE == MD_MULH) || (ex_if.MDOpE == MD_MULHSU) ||
                   (ex_if.MDOpE == MD_DIV)  || (ex_if.MDOpE == MD_REM);
    assign b_sgn = (ex_if.MDOpE == MD_MULH) || (ex_if.MDOpE == MD_DIV) ||
                   (ex_if.MDOpE == MD_REM);
    assign a_neg = a_sgn & src_a[XLEN-1];
    assign b_neg = b_sgn & fwd_b[XLEN-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -fwd_b : fwd_b;
    assign div_zero = ex_if.MDOpE[2] && (fwd_b == '0);
    assign div_ovf  = ex_if.MDOpE[2] && !ex_if.MDOpE[0] &&
                      (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (fwd_b == '1);

    // Multiply: lo holds the multiplier and shifts out as the product shifts in.
    // Divide: lo holds the dividend, quotient bits enter at the bottom, hi is the remainder.
    always_comb begin : md_iter
        logic [XLEN:0] t;
        it_hi = hi_q;
        it_lo = lo_q;
        t     = '0;
        for (int i = 0; i < MD_RADIX_BITS; i++) begin
            if (!op_q[2]) begin
                t = {1'b0, it_hi} + (it_lo[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
                {it_hi, it_lo} = {t, it_lo[XLEN-1:1]};
            end else begin
                t     = {it_hi, it_lo[XLEN-1]};
                it_lo = {it_lo[XLEN-2:0], 1'b0};
                if (t >= {1'b0, dvs_q}) begin
                    t        = t - {1'b0, dvs_q};
                    it_lo[0] = 1'b1;
                end
                it_hi = t[XLEN-1:0];
            end
        end
    end

    assign prod_s = negq_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign quo_s  = negq_q ? -it_lo : it_lo;
    assign rem_s  = negr_q ? -it_hi : it_hi;

    always_comb begin
        case (op_q)
            MD_MUL:                       fin = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fin = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fin = quo_s;
            default:                      fin = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                start = ex_if.ValidE & ex_if.MulDivE & ~ex_if.FlushE;
                if (start) begin
                    op_d   = ex_if.MDOpE;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    cnt_d  = '0;
                    hi_d   = '0;
                    if (div_zero) begin
                        res_d   = ex_if.MDOpE[1] ? src_a : '1;
                        state_d = MD_DONE;
                    end else if (div_ovf) begin
                        res_d   = ex_if.MDOpE[1] ? '0 : src_a;
                        state_d = MD_DONE;
                    end else begin
                        lo_d    = ex_if.MDOpE[2] ? a_mag : b_mag;
                        dvs_d   = ex_if.MDOpE[2] ? b_mag : a_mag;
                        state_d = MD_RUN;
                    end
                end
            end
            MD_RUN: begin
                if (ex_if.FlushE) begin
                    state_d = MD_IDLE;
                end else begin
                    hi_d  = it_hi;
                    lo_d  = it_lo;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == LAST) begin
                        res_d   = fin;
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                done    = ~ex_if.FlushE;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign ex_if.StallMDE = start | (state_q == MD_RUN);
    assign ex_if.MDDoneE  = done;
    assign ex_if.ResultE  = done ? res_q : alu_y;
`else
    logic unused_md;
    assign unused_md      = ^{clk, rst_n, ex_if.MulDivE, ex_if.MDOpE};
    assign ex_if.StallMDE = 1'b0;
    assign ex_if.MDDoneE  = 1'b0;
    assign ex_if.ResultE  = alu_y;
`endif
endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised successor of the pipeline Execute stage.
- Adds full RV32I branch-condition evaluation, JALR target generation and an iterative RV32M multiply/divide unit with a pipeline-stall handshake.
- Sits between the ID/EX and EX/MEM pipeline registers.
- Drives the hazard unit with a busy/stall signal.

Parameters:
- XLEN, 32: datapath width. Must be even, ≥ 8.
- MD_RADIX_BITS, 1: quotient/product bits resolved per cycle (1, 2 or 4). XLEN must be divisible by it.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidE  in  1  Execute slot holds a real instruction
- FlushE  in  1  kill the instruction in Execute
- JumpE, JalrE, BranchE, ALUSrcE, MulDivE  in  1 each  decoded controls
- BranchCondE  in  3  funct3 of branch
- MDOpE  in  3  funct3 of M-op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- ForwardAE, ForwardBE  in  2 each  00 reg, 01 ResultW, 10 ALUResultM, 11 zero
- ALUControlE  in  4  ALU opcode, same encoding as existing ALU
- PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW  in  XLEN each
- ResultE  out  XLEN  ALU result, or M-op result when MDDoneE
- WriteDataE  out  XLEN  forwarded rs2
- PCTargetE  out  XLEN  branch/jump target
- PCSrcE  out  1  redirect fetch
- StallMDE  out  1  hold F/D/E, bubble M
- MDDoneE  out  1  M-op result valid this cycle

Behaviour:
- Forwarding muxes:
  - SrcA = ForwardAE-selected value. WriteDataE = ForwardBE-selected value.
  - SrcB = ALUSrcE ? ExtImmE : WriteDataE.
- Branch condition `taken`, by BranchCondE:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010/011 → 0.
- PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & taken)). Combinational.
- PCTargetE = JalrE ? (SrcA+ExtImmE) with bit0 cleared : PCE+ExtImmE. Wraps mod 2^XLEN.
- M-unit FSM: IDLE, RUN, DONE. Reset → IDLE, counter 0, result register 0.
- start = ValidE & MulDivE & ~FlushE in IDLE.
- IDLE→RUN on start:
  - Latch SrcA, WriteDataE, MDOpE. Later changes in forwarded M/W values are ignored.
  - Signed operands are converted to magnitudes; signs are recorded.
- IDLE→DONE on start with a special case (no iteration):
  - Divide-by-zero: quotient all-ones, remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN, remainder 0.
- RUN:
  - Shift-add multiply (2·XLEN product) or restoring divide.
  - MD_RADIX_BITS bits per cycle. Counter runs 0..XLEN/MD_RADIX_BITS−1.
  - Last iteration applies sign correction and moves to DONE.
- DONE:
  - MDDoneE=1 and ResultE = M result. MULH* return the upper XLEN bits, all others the lower.
  - Next state IDLE.
- StallMDE = start | (state==RUN). Combinational. Deasserts in DONE so the pipeline advances.
- Latency:
  - Normal M-op: StallMDE high for XLEN/MD_RADIX_BITS+1 cycles, then one DONE cycle.
  - Special case: 1 stall cycle, then DONE.
- FlushE in RUN or DONE: next state IDLE, StallMDE low next cycle, no MDDoneE.
- Reset mid-operation: immediate return to IDLE. All registered state cleared asynchronously.
- Non-M instructions: ResultE = ALU result, zero stall.
- M-op with ValidE=0: ignored.

Optional Feature:
- Macro EXEC_MULDIV_EN.
- Defined: M-unit present as above.
- Undefined: no M-unit registers. StallMDE=0, MDDoneE=0, MulDivE ignored, ResultE is always the ALU result.

Test Plan:
- ForwardAE=10, ALUResultM=5, RD2E=3, ALUControlE=ADD, ALUSrcE=0 → ResultE=8, StallMDE=0.
- BranchE=1, BranchCondE=100, SrcA=−1, SrcB=1, PCE=0x100, ExtImmE=0x20 → PCSrcE=1, PCTargetE=0x120. Same with BranchCondE=110 → PCSrcE=0.
- MUL/MULH −3×7 (XLEN=32, radix 1) → StallMDE high 33 cycles, then MDDoneE=1 with ResultE=0xFFFFFFEB (MUL) and 0xFFFFFFFF (MULH).
- DIV 0x80000000 / −1 → 1 stall cycle, ResultE=0x80000000. DIVU 7/0 → 0xFFFFFFFF. REM 7/0 → 7.
- DIV −7/2 → −3. REM −7/2 → −1. Change ALUResultM mid-RUN → result unchanged.
- FlushE at RUN cycle 10, or rst_n low at cycle 5 → IDLE, StallMDE=0 next cycle/immediately, no MDDoneE. A following ADD executes normally.
